four_to_two_event_encoder: RTL and testbench



---
 rtl/encoder_pkg.sv | 27 ++
 rtl/line_debounce.sv | 72 +++++++
 rtl/four_to_two_event_encoder.sv | 107 ++++++++++
 tb/tb_four_to_two_event_encoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
// Shared types and helpers for the four_to_two_event_encoder slice.
//   NUM_LINES    number of request lines handled by the encoder
//   line_idx_t   2-bit line index, emitted on {A,B}
//   highest_set  index of the most significant set bit in a line mask
// ----------------------------------------------------------------------------
package encoder_pkg;

    localparam int NUM_LINES = 4;

    typedef logic [1:0] line_idx_t;

    // Ascending scan so a higher set bit overwrites a lower one; returns 0
    // for an empty mask (callers qualify with |mask).
    function automatic line_idx_t highest_set(input logic [NUM_LINES-1:0] mask);
        line_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (mask[i]) begin
                idx = line_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/line_debounce.sv
// ----------------------------------------------------------------------------
// line_debounce
// One request line: optional two-flop synchronizer, debounce counter and the
// filtered level f. rise is a combinational one-cycle pulse that is high in
// the cycle whose closing clock edge moves f from 0 to 1, so the consumer
// can register the event on the same edge that f rises.
//
// Build option: ENCODER_SYNC_EN defined inserts the two-flop synchronizer;
// undefined feeds d straight into the debouncer (d must then be synchronous).
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive differing cycles before f follows (1..255)
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   d      in   raw request line
//   f      out  debounced level
//   rise   out  high in the cycle f is about to go 0->1
// ----------------------------------------------------------------------------
module line_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic f,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             settle;

`ifdef ENCODER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign s = sync_q[1];
`else
    assign s = d;
`endif

    // The counter only advances while s disagrees with f, so any bounce back
    // to f restarts the qualification window.
    assign settle = (s != f) && (cnt == CNT_LAST);
    assign rise   = settle & s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f   <= 1'b0;
            cnt <= '0;
        end else if (s == f) begin
            cnt <= '0;
        end else if (settle) begin
            f   <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/four_to_two_event_encoder.sv
// ----------------------------------------------------------------------------
// four_to_two_event_encoder
// Return path for the 2-to-4 AND decoder. Each request line is debounced and
// its qualified rising edges are queued in pending[3:0]. Queued events are
// emitted highest line first as {A,B} under a valid/ready handshake, so
// feeding A,B back into the decoder selects the originating line.
//
// Build option: ENCODER_SYNC_EN adds a two-flop synchronizer per line
// (inside line_debounce); without it the lines must be synchronous to clk.
//
// Parameters
//   DEBOUNCE_CYCLES  debounce length in cycles (1..255)
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   D0..D3   in   request lines, active high
//   A, B     out  event code, A = index bit 1, B = index bit 0
//   valid    out  {A,B} holds an event
//   ready    in   consumer accepts when valid & ready at a clock edge
//   overrun  out  sticky: a line rose again before its event was taken
// ----------------------------------------------------------------------------
module four_to_two_event_encoder
    import encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    output logic A,
    output logic B,
    output logic valid,
    input  logic ready,
    output logic overrun
);

    logic [NUM_LINES-1:0] d_in;
    logic [NUM_LINES-1:0] f;
    logic [NUM_LINES-1:0] rise;
    logic [NUM_LINES-1:0] pending;
    logic [NUM_LINES-1:0] pending_nxt;
    logic [NUM_LINES-1:0] clr_mask;
    logic                 slot_free;
    logic                 take;
    logic                 overrun_hit;
    line_idx_t            sel_idx;

    // Filtered levels are kept on the sub-module interface for visibility
    // but the queue only needs the rise pulses.
    logic unused_f;
    assign unused_f = ^f;

    assign d_in = {D3, D2, D1, D0};

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        line_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_line_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d_in[i]),
            .f     (f[i]),
            .rise  (rise[i])
        );
    end

    // A new rise is OR-ed in after the clear, so a set and clear of the same
    // bit on one edge leaves the new event queued. Only a rise onto a bit
    // that stays set counts as an overrun.
    always_comb begin
        slot_free   = ~valid | ready;
        take        = slot_free & (|pending);
        sel_idx     = highest_set(pending);
        clr_mask    = '0;
        if (take) begin
            clr_mask[sel_idx] = 1'b1;
        end
        pending_nxt = (pending & ~clr_mask) | rise;
        overrun_hit = |(rise & pending & ~clr_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= 1'b0;
            valid   <= 1'b0;
            A       <= 1'b0;
            B       <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (overrun_hit) begin
                overrun <= 1'b1;
            end
            if (take) begin
                {A, B} <= sel_idx;
                valid  <= 1'b1;
            end else if (slot_free) begin
                // Code is left as-is so {A,B} only changes with a new event.
                valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_four_to_two_event_encoder.sv
// ----------------------------------------------------------------------------
// tb_four_to_two_event_encoder
// Directed bench with a behavioural reference model. The model keeps, per
// line, a short history of synchronized samples and lets the filtered level
// follow once the last DEBOUNCE_CYCLES samples all disagree with it; the
// output side is a pending mask drained highest-first.
// ----------------------------------------------------------------------------
module tb_four_to_two_event_encoder;

    localparam int DB = 4;
`ifdef ENCODER_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = SYNC + DB + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic D0 = 1'b0, D1 = 1'b0, D2 = 1'b0, D3 = 1'b0;
    logic ready = 1'b1;
    logic A, B, valid, overrun;

    int checks = 0;
    int errors = 0;

    four_to_two_event_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .D0      (D0),
        .D1      (D1),
        .D2      (D2),
        .D3      (D3),
        .A       (A),
        .B       (B),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0]    d;
    logic [1:0]    dh [4];
    logic [1:0]    dh_n [4];
    logic [2:0]    tap [4];
    logic [DB-1:0] hs [4];
    logic [DB-1:0] hs_n [4];
    logic [3:0]    mf, mf_n, rise_m, pend, pend_n, clr;
    logic          mval, mval_n, movr, movr_n;
    logic [1:0]    mcode, mcode_n;
    int            top_idx;

    assign d = {D3, D2, D1, D0};

    always_comb begin
        mf_n    = mf;
        rise_m  = '0;
        clr     = '0;
        mval_n  = mval;
        mcode_n = mcode;
        top_idx = 0;
        for (int i = 0; i < 4; i++) begin
            tap[i]  = {dh[i], d[i]};
            dh_n[i] = {dh[i][0], d[i]};
            hs_n[i] = {hs[i][DB-2:0], tap[i][SYNC]};
            if (hs_n[i] == {DB{~mf[i]}}) begin
                mf_n[i]   = ~mf[i];
                rise_m[i] = ~mf[i];
            end
        end
        if (!mval || ready) begin
            if (pend != 0) begin
                top_idx = $clog2(int'(pend) + 1) - 1;
                clr[top_idx] = 1'b1;
                mval_n  = 1'b1;
                mcode_n = 2'(top_idx);
            end else begin
                mval_n = 1'b0;
            end
        end
        movr_n = movr | (|(rise_m & pend & ~clr));
        pend_n = (pend & ~clr) | rise_m;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                dh[i] <= '0;
                hs[i] <= '0;
            end
            mf    <= '0;
            pend  <= '0;
            mval  <= 1'b0;
            movr  <= 1'b0;
            mcode <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                dh[i] <= dh_n[i];
                hs[i] <= hs_n[i];
            end
            mf    <= mf_n;
            pend  <= pend_n;
            mval  <= mval_n;
            movr  <= movr_n;
            mcode <= mcode_n;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ({A, B, valid, overrun} !== {mcode, mval, movr}) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual A=%b B=%b valid=%b overrun=%b required code=%0d valid=%b overrun=%b",
                         $time, A, B, valid, overrun, mcode, mval, movr);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges from now until valid is seen (bounded).
    task automatic wait_valid(input string name, input int exp_n);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (valid) seen = 1'b1;
        end
        chk(name, n, exp_n);
    endtask

    task automatic count_valid(input int cycles, output int cnt, output int last_code);
        cnt = 0;
        last_code = -1;
        repeat (cycles) begin
            @(negedge clk);
            if (valid) begin
                cnt++;
                last_code = int'({A, B});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int code;

        // Reset
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("reset_A", int'(A), 0);
        chk("reset_B", int'(B), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_overrun", int'(overrun), 0);

        // D2 single event, latency and one-cycle valid
        D2 = 1'b1;
        wait_valid("d2_latency", LAT);
        chk("d2_code", int'({A, B}), 2);
        chk("d2_model_code", int'(mcode), 2);
        tick(1);
        chk("d2_one_cycle", int'(valid), 0);
        tick(5);
        D2 = 1'b0;
        count_valid(15, cnt, code);
        chk("d2_fall_no_event", cnt, 0);

        // D1 glitch (3 cycles) then 4-cycle pulse
        D1 = 1'b1;
        tick(3);
        D1 = 1'b0;
        count_valid(15, cnt, code);
        chk("d1_glitch_no_event", cnt, 0);
        D1 = 1'b1;
        tick(4);
        D1 = 1'b0;
        count_valid(15, cnt, code);
        chk("d1_pulse_events", cnt, 1);
        chk("d1_pulse_code", code, 1);

        // All four lines together
        {D3, D2, D1, D0} = 4'b1111;
        wait_valid("all_latency", LAT);
        chk("all_code0", int'({A, B}), 3);
        tick(1);
        chk("all_valid1", int'(valid), 1);
        chk("all_code1", int'({A, B}), 2);
        tick(1);
        chk("all_code2", int'({A, B}), 1);
        tick(1);
        chk("all_code3", int'({A, B}), 0);
        chk("all_model_code3", int'(mcode), 0);
        tick(1);
        chk("all_drain", int'(valid), 0);
        {D3, D2, D1, D0} = 4'b0000;
        tick(12);

        // D3 stalled by ready=0
        ready = 1'b0;
        D3 = 1'b1;
        wait_valid("stall_latency", LAT);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("stall_valid", int'(valid), 1);
            chk("stall_code", int'({A, B}), 3);
        end
        ready = 1'b1;
        tick(1);
        chk("stall_accept_drop", int'(valid), 0);
        D3 = 1'b0;
        tick(12);

        // Overrun: two D0 pulses behind a stalled D3 event
        ready = 1'b0;
        D3 = 1'b1;
        wait_valid("ovr_d3_latency", LAT);
        D0 = 1'b1; tick(5);
        D0 = 1'b0; tick(6);
        D0 = 1'b1; tick(5);
        D0 = 1'b0; tick(10);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_d3_held", int'({A, B}), 3);
        ready = 1'b1;
        tick(1);
        chk("ovr_d0_valid", int'(valid), 1);
        chk("ovr_d0_code", int'({A, B}), 0);
        count_valid(10, cnt, code);
        chk("ovr_single_d0", cnt, 0);
        chk("ovr_sticky", int'(overrun), 1);
        D3 = 1'b0;
        tick(12);

        // Asynchronous reset mid-event, then line held high through reset
        ready = 1'b0;
        D2 = 1'b1;
        wait_valid("rst_pre_latency", LAT);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_overrun", int'(overrun), 0);
        chk("async_rst_code", int'({A, B}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        wait_valid("held_high_latency", LAT);
        chk("held_high_code", int'({A, B}), 2);
        D2 = 1'b0;
        tick(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
